gfx_layer_compositor: RTL and testbench

Per-pixel graphics controller that generates the 8-bit `color_data` stream consumed by the VGA output stage. It composites one solid background layer and two square sprites, and arbitrates between them with a fixed, configurable priority. A configuration port writes shadow registers, which are committed atomically at frame start so the picture never tears. It sits between the pixel-timing logic (pixel coordinates in) and the VGA colour input (colour out), on the pixel clock.

---
 rtl/gfx_layer_compositor_pkg.sv | 25 ++
 rtl/gfx_layer_compositor_sprite_hit.sv | 26 ++
 rtl/gfx_layer_compositor.sv | 147 ++++++++++++++
 tb/tb_gfx_layer_compositor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_layer_compositor_pkg.sv
// Shared definitions for the layer compositor: register map, CTRL bit
// positions and colour constants.
package gfx_pkg;

  localparam int COLOR_W = 8;
  typedef logic [COLOR_W-1:0] color_t;
  localparam color_t BLACK = 8'h00;

  typedef enum logic [3:0] {
    ADDR_BG_COLOR = 4'd0,
    ADDR_S0_X     = 4'd1,
    ADDR_S0_Y     = 4'd2,
    ADDR_S0_COLOR = 4'd3,
    ADDR_S1_X     = 4'd4,
    ADDR_S1_Y     = 4'd5,
    ADDR_S1_COLOR = 4'd6,
    ADDR_CTRL     = 4'd7
  } cfg_addr_e;

  localparam int CTRL_W          = 3;
  localparam int CTRL_S0_EN      = 0;
  localparam int CTRL_S1_EN      = 1;
  localparam int CTRL_S1_OVER_S0 = 2;

endpackage

// File: rtl/gfx_layer_compositor_sprite_hit.sv
// Combinational test of whether a pixel lies inside a square sprite.
// One extra bit of headroom keeps sprites near the coordinate limit from wrapping.
module sprite_hit #(
  parameter int COORD_W = 10,
  parameter int SIZE    = 16
) (
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic [COORD_W-1:0] sprite_x,
  input  logic [COORD_W-1:0] sprite_y,
  output logic               hit
);

  localparam logic [COORD_W:0] SIZE_EXT = (COORD_W+1)'(SIZE);

  logic [COORD_W:0] px, py, sx, sy;

  assign px = {1'b0, pixel_x};
  assign py = {1'b0, pixel_y};
  assign sx = {1'b0, sprite_x};
  assign sy = {1'b0, sprite_y};

  assign hit = (px >= sx) && (px < sx + SIZE_EXT) &&
               (py >= sy) && (py < sy + SIZE_EXT);

endmodule

// File: rtl/gfx_layer_compositor.sv
// Background plus two sprites composited per pixel, with shadow registers
// committed at frame_start. Define STT8_COLLISION_EN to build sprite collision detection.
module gfx_layer_compositor
  import gfx_pkg::*;
#(
  parameter int SPRITE_SIZE = 16,
  parameter int COORD_W     = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               video_active,
  input  logic               frame_start,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [3:0]         cfg_addr,
  input  logic [9:0]         cfg_data,
  output logic [7:0]         color_data,
  output logic               collision
);

  color_t              bg_sh, s0_c_sh, s1_c_sh;
  logic [COORD_W-1:0]  s0_x_sh, s0_y_sh, s1_x_sh, s1_y_sh;
  logic [CTRL_W-1:0]   ctrl_sh;

  color_t              bg_act, s0_c_act, s1_c_act;
  logic [COORD_W-1:0]  s0_x_act, s0_y_act, s1_x_act, s1_y_act;
  logic [CTRL_W-1:0]   ctrl_act;

  logic   cfg_fire;
  logic   s0_hit, s1_hit, s0_on, s1_on;
  color_t pixel_color;

  // The commit cycle owns the shadow registers, so writes are held off then.
  assign cfg_ready = ~frame_start;
  assign cfg_fire  = cfg_valid & cfg_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bg_sh   <= BLACK;
      s0_x_sh <= '0;
      s0_y_sh <= '0;
      s0_c_sh <= BLACK;
      s1_x_sh <= '0;
      s1_y_sh <= '0;
      s1_c_sh <= BLACK;
      ctrl_sh <= '0;
    end else if (cfg_fire) begin
      case (cfg_addr_e'(cfg_addr))
        ADDR_BG_COLOR: bg_sh   <= cfg_data[COLOR_W-1:0];
        ADDR_S0_X:     s0_x_sh <= COORD_W'(cfg_data);
        ADDR_S0_Y:     s0_y_sh <= COORD_W'(cfg_data);
        ADDR_S0_COLOR: s0_c_sh <= cfg_data[COLOR_W-1:0];
        ADDR_S1_X:     s1_x_sh <= COORD_W'(cfg_data);
        ADDR_S1_Y:     s1_y_sh <= COORD_W'(cfg_data);
        ADDR_S1_COLOR: s1_c_sh <= cfg_data[COLOR_W-1:0];
        ADDR_CTRL:     ctrl_sh <= cfg_data[CTRL_W-1:0];
        default:       ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bg_act   <= BLACK;
      s0_x_act <= '0;
      s0_y_act <= '0;
      s0_c_act <= BLACK;
      s1_x_act <= '0;
      s1_y_act <= '0;
      s1_c_act <= BLACK;
      ctrl_act <= '0;
    end else if (frame_start) begin
      bg_act   <= bg_sh;
      s0_x_act <= s0_x_sh;
      s0_y_act <= s0_y_sh;
      s0_c_act <= s0_c_sh;
      s1_x_act <= s1_x_sh;
      s1_y_act <= s1_y_sh;
      s1_c_act <= s1_c_sh;
      ctrl_act <= ctrl_sh;
    end
  end

  sprite_hit #(.COORD_W(COORD_W), .SIZE(SPRITE_SIZE)) u_s0_hit (
    .pixel_x  (pixel_x),
    .pixel_y  (pixel_y),
    .sprite_x (s0_x_act),
    .sprite_y (s0_y_act),
    .hit      (s0_hit)
  );

  sprite_hit #(.COORD_W(COORD_W), .SIZE(SPRITE_SIZE)) u_s1_hit (
    .pixel_x  (pixel_x),
    .pixel_y  (pixel_y),
    .sprite_x (s1_x_act),
    .sprite_y (s1_y_act),
    .hit      (s1_hit)
  );

  assign s0_on = s0_hit & ctrl_act[CTRL_S0_EN];
  assign s1_on = s1_hit & ctrl_act[CTRL_S1_EN];

  always_comb begin
    pixel_color = bg_act;
    if (s1_on && (ctrl_act[CTRL_S1_OVER_S0] || !s0_on)) begin
      pixel_color = s1_c_act;
    end else if (s0_on) begin
      pixel_color = s0_c_act;
    end
    if (!video_active) begin
      pixel_color = BLACK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      color_data <= BLACK;
    end else begin
      color_data <= pixel_color;
    end
  end

`ifdef STT8_COLLISION_EN
  logic collision_flag;
  logic both_hit;

  assign both_hit = video_active & s0_on & s1_on;

  // A hit in the commit cycle belongs to the frame that is just starting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      collision_flag <= 1'b0;
      collision      <= 1'b0;
    end else if (frame_start) begin
      collision      <= collision_flag;
      collision_flag <= both_hit;
    end else begin
      collision_flag <= collision_flag | both_hit;
    end
  end
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_gfx_layer_compositor.sv
// Directed bench for gfx_layer_compositor with a register-array reference
// model checked every cycle plus hand-computed spot checks.
module tb_gfx_layer_compositor;

  localparam int SPRITE_SIZE = 16;
  localparam int COORD_W     = 10;
`ifdef STT8_COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic               video_active;
  logic               frame_start;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [3:0]         cfg_addr;
  logic [9:0]         cfg_data;
  logic [7:0]         color_data;
  logic               collision;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  gfx_layer_compositor #(.SPRITE_SIZE(SPRITE_SIZE), .COORD_W(COORD_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .video_active (video_active),
    .frame_start  (frame_start),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .color_data   (color_data),
    .collision    (collision)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: registers as plain int arrays indexed by address.
  int   sh  [8];
  int   act [8];
  logic [7:0] m_color;
  logic       m_coll;
  bit         m_flag;

  function automatic bit in_sprite(int s, int px, int py);
    int sx, sy;
    sx = act[1 + 3*s];
    sy = act[2 + 3*s];
    return ((act[7] >> s) & 1) == 1 &&
           px >= sx && px < sx + SPRITE_SIZE &&
           py >= sy && py < sy + SPRITE_SIZE;
  endfunction

  function automatic logic [7:0] model_color(int px, int py, bit va);
    int order [2];
    if (!va) return 8'h00;
    if (((act[7] >> 2) & 1) == 1) order = '{1, 0};
    else                          order = '{0, 1};
    foreach (order[i]) begin
      if (in_sprite(order[i], px, py)) return 8'(act[3 + 3*order[i]] & 'hFF);
    end
    return 8'(act[0] & 'hFF);
  endfunction

  always @(posedge clk) begin
    bit both;
    if (!rst_n) begin
      foreach (sh[i]) begin
        sh[i]  = 0;
        act[i] = 0;
      end
      m_color = 8'h00;
      m_coll  = 1'b0;
      m_flag  = 1'b0;
    end else begin
      m_color = model_color(int'(pixel_x), int'(pixel_y), video_active);
      both = video_active && in_sprite(0, int'(pixel_x), int'(pixel_y)) &&
             in_sprite(1, int'(pixel_x), int'(pixel_y));
      if (frame_start) begin
        m_coll = COLL_EN ? m_flag : 1'b0;
        m_flag = both;
        foreach (act[i]) act[i] = sh[i];
      end else begin
        m_flag = m_flag | both;
      end
      if (cfg_valid && !frame_start && cfg_addr < 4'd8) sh[cfg_addr] = int'(cfg_data);
    end
  end

  task automatic checkOutput(input string name, input logic [9:0] actual,
                             input logic [9:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("color_stream", color_data, m_color);
      checkOutput("collision_stream", collision, m_coll);
      checkOutput("cfg_ready_stream", cfg_ready, !frame_start);
    end
  end

  // Drive one pixel-clock cycle of inputs; returns just after the capturing edge.
  task automatic applyStimulus(input int px, input int py, input bit va, input bit fs,
                               input bit cv, input int ca, input int cd);
    pixel_x      = COORD_W'(px);
    pixel_y      = COORD_W'(py);
    video_active = va;
    frame_start  = fs;
    cfg_valid    = cv;
    cfg_addr     = 4'(ca);
    cfg_data     = 10'(cd);
    @(posedge clk);
    #2;
  endtask

  task automatic write_reg(input int a, input int d);
    applyStimulus(0, 0, 1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic commit();
    applyStimulus(0, 0, 1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic pixel(input int px, input int py);
    applyStimulus(px, py, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  int xs  [4] = '{99, 100, 115, 116};
  int exs [4] = '{'h1C, 'hE0, 'hE0, 'h1C};

  initial begin
    rst_n = 1'b0;
    pixel_x = '0; pixel_y = '0; video_active = 1'b1; frame_start = 1'b0;
    cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    check_en = 1'b1;
    checkOutput("reset_color", color_data, 10'h00);
    checkOutput("reset_collision", collision, 10'h0);
    checkOutput("reset_cfg_ready", cfg_ready, 10'h1);
    rst_n = 1'b1;

    pixel(10, 10);
    checkOutput("post_reset_color", color_data, 10'h00);

    write_reg(0, 'h1C);
    pixel(10, 10);
    checkOutput("bg_before_commit", color_data, 10'h00);
    commit();
    checkOutput("commit_cycle_old_cfg", color_data, 10'h00);
    pixel(10, 10);
    checkOutput("bg_after_commit", color_data, 10'h1C);

    write_reg(1, 100); write_reg(2, 50); write_reg(3, 'hE0); write_reg(7, 1);
    commit();
    for (int x = 98; x <= 117; x++) pixel(x, 50);
    foreach (xs[i]) begin
      pixel(xs[i], 50);
      checkOutput("s0_edge_x", color_data, 10'(exs[i]));
    end
    pixel(100, 49);
    checkOutput("s0_above", color_data, 10'h1C);
    pixel(100, 65);
    checkOutput("s0_last_row", color_data, 10'hE0);
    pixel(100, 66);
    checkOutput("s0_below", color_data, 10'h1C);

    write_reg(1, 1020); write_reg(2, 0);
    commit();
    pixel(1023, 0);
    checkOutput("clip_last_col", color_data, 10'hE0);
    pixel(1019, 0);
    checkOutput("clip_before", color_data, 10'h1C);
    pixel(3, 0);
    checkOutput("clip_no_wrap", color_data, 10'h1C);

    write_reg(1, 200); write_reg(2, 200);
    write_reg(4, 200); write_reg(5, 200); write_reg(6, 'h03); write_reg(7, 3);
    commit();
    pixel(205, 205);
    checkOutput("s0_over_s1", color_data, 10'hE0);
    write_reg(7, 7);
    commit();
    checkOutput("collision_set", collision, COLL_EN ? 10'h1 : 10'h0);
    pixel(205, 205);
    checkOutput("s1_over_s0", color_data, 10'h03);
    write_reg(4, 500);
    commit();
    pixel(205, 205);
    checkOutput("s0_alone", color_data, 10'hE0);
    commit();
    checkOutput("collision_clear", collision, 10'h0);

    pixel_x = '0; pixel_y = '0; video_active = 1'b1; frame_start = 1'b1;
    cfg_valid = 1'b1; cfg_addr = 4'd0; cfg_data = 10'hFF;
    #1;
    checkOutput("cfg_ready_stall", cfg_ready, 10'h0);
    @(posedge clk);
    #2;
    applyStimulus(0, 0, 1'b1, 1'b0, 1'b1, 0, 'hFF);
    pixel(0, 0);
    checkOutput("stall_write_not_live", color_data, 10'h1C);
    commit();
    pixel(0, 0);
    checkOutput("stall_write_after_commit", color_data, 10'hFF);

    applyStimulus(205, 205, 1'b0, 1'b0, 1'b0, 0, 0);
    checkOutput("blank_on_hit", color_data, 10'h00);

    rst_n = 1'b0;
    pixel(205, 205);
    checkOutput("reset_midline", color_data, 10'h00);
    rst_n = 1'b1;
    commit();
    pixel(205, 205);
    checkOutput("config_cleared", color_data, 10'h00);

    repeat (3) pixel(20, 20);
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
